// File: rtl/simon_button_conditioner_if.sv
// Button-conditioner signal bundle.
// master: the side that owns the raw button (board / testbench).
// slave : the conditioner itself.
interface simon_button_conditioner_if;
    logic       btn_raw;      // raw push-button, asynchronous and bouncy
    logic       pclk;         // conditioned press pulse for Simon
    logic       btn_stable;   // debounced button level
    logic [7:0] press_count;  // accepted presses, wraps

    modport master (
        output btn_raw,
        input  pclk,
        input  btn_stable,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        output pclk,
        output btn_stable,
        output press_count
    );
endinterface

// File: rtl/simon_button_conditioner.sv
// Simon push-button conditioner.
// Synchronizes the raw button into sysclk, debounces press and release with
// a shared counter, and emits one fixed-width pclk pulse per accepted press.
// Every output comes straight from a flop, so nothing from btn_raw reaches
// pclk combinationally.
module simon_button_conditioner #(
    parameter int CNT_W     = 20,
    parameter int DEBOUNCE  = 1000000,
    parameter int PULSE_LEN = 4
) (
    input  logic                       sysclk,
    input  logic                       rst,
    simon_button_conditioner_if.slave  btn_if
);

    // FSM encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_DISARM  = 2'd3;

    // Debounce terminal count: DEBOUNCE+1 consecutive samples including the
    // edge that enters ARM/DISARM with cnt=0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    // Pulse counter only needs to hold PULSE_LEN-1.
    localparam int              PW        = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0]   PCNT_LOAD = PW'(PULSE_LEN - 1);

    logic             sync1_q, sync2_q;
    logic             btn_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;        // press debounced this edge
    logic             release_done;  // release debounced this edge
    logic             pclk_q, pclk_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             stable_q, stable_d;
    logic [7:0]       count_q, count_d;

    assign btn_s = sync2_q;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_if.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next state; one counter serves both press and release
    // because the two windows can never overlap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        release_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (!btn_s) begin
                    // Glitch: drop back silently, counter is reloaded on re-entry.
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!btn_s) begin
                    state_d = S_DISARM;
                    cnt_d   = '0;
                end
            end
            S_DISARM: begin
                if (btn_s) begin
                    // Release bounce: the press is still the same press.
                    state_d = S_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_IDLE;
                    release_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulse generator and debug outputs. An acceptance during an active
    // pulse only reloads the down-counter, so pclk never re-rises.
    always_comb begin
        pclk_d   = pclk_q;
        pcnt_d   = pcnt_q;
        stable_d = stable_q;
        count_d  = count_q;
        if (accept) begin
            pclk_d   = 1'b1;
            pcnt_d   = PCNT_LOAD;
            stable_d = 1'b1;
            count_d  = count_q + 8'd1;   // natural 8-bit wrap
        end else begin
            if (pclk_q) begin
                if (pcnt_q == '0) pclk_d = 1'b0;
                else              pcnt_d = pcnt_q - 1'b1;
            end
            if (release_done) stable_d = 1'b0;
        end
    end

    // State and output registers; reset drops pclk immediately.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pclk_q   <= 1'b0;
            pcnt_q   <= '0;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pclk_q   <= pclk_d;
            pcnt_q   <= pcnt_d;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign btn_if.pclk        = pclk_q;
    assign btn_if.btn_stable  = stable_q;
    assign btn_if.press_count = count_q;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Bench for simon_button_conditioner with DEBOUNCE=4, PULSE_LEN=2.
// Reference model: the debounced level flips after DEBOUNCE+1 consecutive
// synchronized samples disagreeing with it; a 0->1 flip is a press that
// starts a PULSE_LEN-cycle pulse and bumps the press count.
module tb_simon_button_conditioner;
    localparam int DEB = 4;
    localparam int PL  = 2;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    simon_button_conditioner_if bus();

    simon_button_conditioner #(
        .CNT_W     (20),
        .DEBOUNCE  (DEB),
        .PULSE_LEN (PL)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .btn_if (bus)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit m_s1, m_s2, m_lvl;
    int m_run, m_left, m_cnt;
    bit m_acc, m_lvl_n;
    int m_run_n, m_left_n, m_cnt_n;

    always_comb begin
        m_acc   = 1'b0;
        m_lvl_n = m_lvl;
        m_run_n = (m_s2 != m_lvl) ? m_run + 1 : 0;
        if (m_run_n == DEB + 1) begin
            m_run_n = 0;
            m_lvl_n = ~m_lvl;
            m_acc   = ~m_lvl;
        end
        m_left_n = m_acc ? PL : ((m_left > 0) ? m_left - 1 : 0);
        m_cnt_n  = m_acc ? (m_cnt + 1) % 256 : m_cnt;
    end

    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            m_s1 <= 0; m_s2 <= 0; m_lvl <= 0;
            m_run <= 0; m_left <= 0; m_cnt <= 0;
        end else begin
            m_s1   <= bus.btn_raw;
            m_s2   <= m_s1;
            m_lvl  <= m_lvl_n;
            m_run  <= m_run_n;
            m_left <= m_left_n;
            m_cnt  <= m_cnt_n;
        end
    end

    // ---------------- compare + pulse monitor ----------------
    int pulses = 0, bad_w = 0, w = 0, falls = 0;
    bit prev_p = 0, prev_s = 0;

    always @(negedge sysclk) begin
        chk("model_pclk",  int'(bus.pclk),        (m_left > 0) ? 1 : 0);
        chk("model_stbl",  int'(bus.btn_stable),  int'(m_lvl));
        chk("model_count", int'(bus.press_count), m_cnt);
        if (rst) begin
            prev_p = 0; prev_s = 0; w = 0;
        end else begin
            if (bus.pclk) begin
                if (!prev_p) pulses++;
                w++;
            end else if (prev_p) begin
                if (w != PL) bad_w++;
                w = 0;
            end
            if (prev_s && !bus.btn_stable) falls++;
            prev_p = bus.pclk;
            prev_s = bus.btn_stable;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    int p0, f0, bw0;

    initial begin
        bus.btn_raw = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("rst_pclk",  int'(bus.pclk), 0);
        chk("rst_count", int'(bus.press_count), 0);
        rst = 1'b0;

        // 1: idle after reset
        p0 = pulses;
        tick(20); #1;
        chk("t1_pulses", pulses - p0, 0);
        chk("t1_count",  int'(bus.press_count), 0);
        chk("t1_stable", int'(bus.btn_stable), 0);

        // 2: clean press, latency DEBOUNCE+3 edges
        tick(1);
        bus.btn_raw = 1'b1;
        p0 = pulses;
        tick(6);
        chk("t2_pclk_e6",   int'(bus.pclk), 0);
        chk("t2_stable_e6", int'(bus.btn_stable), 0);
        tick(1);
        chk("t2_pclk_e7",   int'(bus.pclk), 1);
        chk("t2_stable_e7", int'(bus.btn_stable), 1);
        chk("t2_count_e7",  int'(bus.press_count), 1);
        tick(1);
        chk("t2_pclk_e8", int'(bus.pclk), 1);
        tick(1);
        chk("t2_pclk_e9", int'(bus.pclk), 0);
        tick(11); #1;
        chk("t2_pulses", pulses - p0, 1);

        // 4: release bounce after an accepted press
        tick(1);
        f0 = falls; p0 = pulses;
        bus.btn_raw = 1'b0; tick(2);
        bus.btn_raw = 1'b1; tick(2);
        bus.btn_raw = 1'b0; tick(20); #1;
        chk("t4_pulses", pulses - p0, 0);
        chk("t4_falls",  falls - f0, 1);
        chk("t4_count",  int'(bus.press_count), 1);
        chk("t4_stable", int'(bus.btn_stable), 0);

        // 3: bounce shorter than the debounce window, from fresh reset
        tick(1);
        rst = 1'b1; tick(2); rst = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            bus.btn_raw = (i % 2 == 0);
            tick(2);
        end
        bus.btn_raw = 1'b0;
        tick(10); #1;
        chk("t3_pulses", pulses - p0, 0);
        chk("t3_count",  int'(bus.press_count), 0);

        // 5: reset mid-pulse with button held, then re-acceptance
        tick(1);
        bus.btn_raw = 1'b1;
        tick(7);
        chk("t5_pclk_pre", int'(bus.pclk), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_pclk_rst",  int'(bus.pclk), 0);
        chk("t5_count_rst", int'(bus.press_count), 0);
        tick(2);
        #2 rst = 1'b0;
        p0 = pulses;
        tick(6);
        chk("t5_pclk_e6", int'(bus.pclk), 0);
        tick(1);
        chk("t5_pclk_e7", int'(bus.pclk), 1);
        tick(30); #1;
        chk("t5_pulses", pulses - p0, 1);
        chk("t5_count",  int'(bus.press_count), 1);

        // 6: 256 clean presses, press_count wraps to 0
        tick(1);
        bus.btn_raw = 1'b0;
        rst = 1'b1; tick(2); rst = 1'b0;
        p0 = pulses; bw0 = bad_w;
        for (int i = 0; i < 256; i++) begin
            bus.btn_raw = 1'b1; tick(20);
            bus.btn_raw = 1'b0; tick(20);
        end
        #1;
        chk("t6_pulses", pulses - p0, 256);
        chk("t6_widths", bad_w - bw0, 0);
        chk("t6_count",  int'(bus.press_count), 0);
        chk("all_widths", bad_w, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
